// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pkg
// Purpose  : Shared defaults and width helpers for the FIFO read-side drain
//            controller (fifo_rd_ctrl) and its byte packer (fifo_rd_pack).
// Contents : DATA_W_DEF / PACK_DEF default geometry, WORD_W_DEF word width,
//            bytes_w() width of the valid-byte count, word_w() packed width.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int PACK_DEF   = 4;
  localparam int WORD_W_DEF = DATA_W_DEF * PACK_DEF;

  // Width needed to hold a byte count in the range 0..pack.
  function automatic int bytes_w(input int pack);
    return $clog2(pack) + 1;
  endfunction

  // Width of one packed output word.
  function automatic int word_w(input int data_w, input int pack);
    return data_w * pack;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_pack.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_pack
// Purpose  : Byte-slot pack register. Captures one FIFO entry per cap_en into
//            slot cnt, counts captured entries and presents the zero-padded
//            word including any byte captured this cycle.
// Ports    : clk, rst_n (sync, active-low)
//            cap_en / cap_data : write cap_data into slot cnt, cnt increments
//            clear             : empty the register (word has moved out)
//            cnt               : entries currently held
//            cnt_next          : entries held once this cycle's capture lands
//            word_next         : packed word including this cycle's capture
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_pack
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int PACK   = PACK_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cap_en,
  input  logic [DATA_W-1:0]             cap_data,
  input  logic                          clear,
  output logic [bytes_w(PACK)-1:0]      cnt,
  output logic [bytes_w(PACK)-1:0]      cnt_next,
  output logic [word_w(DATA_W,PACK)-1:0] word_next
);

  localparam int BW = bytes_w(PACK);

  logic [PACK-1:0][DATA_W-1:0] slots_q, slots_d, slots_cap;
  logic [BW-1:0]               cnt_q, cnt_d;

  always_comb begin
    slots_cap = slots_q;
    for (int i = 0; i < PACK; i++) begin
      if (cap_en && (cnt_q == BW'(i))) begin
        slots_cap[i] = cap_data;
      end
    end
    cnt_next = cnt_q + BW'(cap_en);

    // Slots are zeroed whenever the word leaves, so unused slots of a
    // partial word are already zero and need no masking.
    if (clear) begin
      slots_d = '0;
      cnt_d   = '0;
    end else begin
      slots_d = slots_cap;
      cnt_d   = cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slots_q <= '0;
      cnt_q   <= '0;
    end else begin
      slots_q <= slots_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cnt       = cnt_q;
  assign word_next = slots_cap;

endmodule
`default_nettype wire

// File: rtl/fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_ctrl
// Purpose  : Read-side drain controller for the dual-clock FIFO. Issues pops
//            while the FIFO is non-empty, absorbs the one-cycle registered
//            read latency, packs PACK entries per word and offers each word on
//            a valid/ready stream. A flush emits the current partial word.
// Ports    : rd_clk, rd_rst_n (sync, active-low)
//            fifo_empty, fifo_rd_en, fifo_rd_data : FIFO read port
//            flush                                : emit partial word
//            m_data, m_bytes, m_valid, m_ready    : output stream
//            m_parity (optional)                  : XOR reduction of m_data
// Config   : FIFO_RD_CTRL_PARITY_EN adds the registered m_parity output.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int PACK   = PACK_DEF
) (
  input  logic                           rd_clk,
  input  logic                           rd_rst_n,
  input  logic                           fifo_empty,
  output logic                           fifo_rd_en,
  input  logic [DATA_W-1:0]              fifo_rd_data,
  input  logic                           flush,
  output logic [word_w(DATA_W,PACK)-1:0] m_data,
  output logic [bytes_w(PACK)-1:0]       m_bytes,
  output logic                           m_valid,
  input  logic                           m_ready
`ifdef FIFO_RD_CTRL_PARITY_EN
  ,
  output logic                           m_parity
`endif
);

  localparam int              BW     = bytes_w(PACK);
  localparam int              WW     = word_w(DATA_W, PACK);
  localparam logic [BW-1:0]   PACK_C = BW'(PACK);

  logic [BW-1:0] cnt, cnt_next;
  logic [WW-1:0] word_next;

  logic          inflight_q, inflight_d;
  logic          flush_pend_q, flush_pend_d;
  logic          m_valid_q, m_valid_d;
  logic [WW-1:0] m_data_q, m_data_d;
  logic [BW-1:0] m_bytes_q, m_bytes_d;
  logic [BW:0]   occ;
  logic          room, slot_free, flush_req, flush_live, emit;
`ifdef FIFO_RD_CTRL_PARITY_EN
  logic          m_parity_q, m_parity_d;
`endif

  fifo_rd_pack #(
    .DATA_W (DATA_W),
    .PACK   (PACK)
  ) u_pack (
    .clk       (rd_clk),
    .rst_n     (rd_rst_n),
    .cap_en    (inflight_q),
    .cap_data  (fifo_rd_data),
    .clear     (emit),
    .cnt       (cnt),
    .cnt_next  (cnt_next),
    .word_next (word_next)
  );

  always_comb begin
    // Held plus in-flight entries must leave room, otherwise a pop would
    // overrun the pack register.
    occ        = {1'b0, cnt} + {{BW{1'b0}}, inflight_q};
    room       = occ < {1'b0, PACK_C};
    slot_free  = !m_valid_q || m_ready;
    flush_req  = flush || flush_pend_q;
    // A flush only matters when there is something to emit.
    flush_live = flush_req && ((cnt != '0) || inflight_q);
    fifo_rd_en = rd_rst_n && !fifo_empty && room && !flush_live;
    inflight_d = fifo_rd_en;

    emit         = 1'b0;
    flush_pend_d = 1'b0;
    if (inflight_q) begin
      // Completing capture loads straight into the output slot; a flush
      // coinciding with completion is absorbed by it.
      emit         = (cnt_next == PACK_C) && slot_free;
      flush_pend_d = flush_req && (cnt_next != PACK_C);
    end else begin
      emit         = slot_free && ((cnt == PACK_C) || (flush_req && (cnt != '0)));
      flush_pend_d = flush_req && (cnt != '0) && (cnt != PACK_C) && !emit;
    end

    m_valid_d = m_valid_q && !m_ready;
    m_data_d  = m_data_q;
    m_bytes_d = m_bytes_q;
    if (emit) begin
      m_valid_d = 1'b1;
      m_data_d  = word_next;
      m_bytes_d = cnt_next;
    end
`ifdef FIFO_RD_CTRL_PARITY_EN
    m_parity_d = emit ? ^word_next : m_parity_q;
`endif
  end

  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      inflight_q   <= 1'b0;
      flush_pend_q <= 1'b0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_bytes_q    <= '0;
`ifdef FIFO_RD_CTRL_PARITY_EN
      m_parity_q   <= 1'b0;
`endif
    end else begin
      inflight_q   <= inflight_d;
      flush_pend_q <= flush_pend_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_bytes_q    <= m_bytes_d;
`ifdef FIFO_RD_CTRL_PARITY_EN
      m_parity_q   <= m_parity_d;
`endif
    end
  end

  assign m_data  = m_data_q;
  assign m_bytes = m_bytes_q;
  assign m_valid = m_valid_q;
`ifdef FIFO_RD_CTRL_PARITY_EN
  assign m_parity = m_parity_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_rd_ctrl
// Purpose  : Self-checking bench for fifo_rd_ctrl. A registered-read FIFO
//            model feeds the DUT; a byte-grouping model predicts the word
//            stream and every handshake is scored against it each cycle.
// Config   : FIFO_RD_CTRL_PARITY_EN enables m_parity checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_ctrl;

  localparam int DATA_W = 8;
  localparam int PACK   = 4;

  logic        rd_clk = 1'b0;
  logic        rd_rst_n;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rd_data;
  logic        flush;
  logic [31:0] m_data;
  logic [2:0]  m_bytes;
  logic        m_valid;
  logic        m_ready;
`ifdef FIFO_RD_CTRL_PARITY_EN
  logic        m_parity;
`endif

  always #5 rd_clk = ~rd_clk;

  fifo_rd_ctrl #(
    .DATA_W (DATA_W),
    .PACK   (PACK)
  ) dut (
    .rd_clk       (rd_clk),
    .rd_rst_n     (rd_rst_n),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .flush        (flush),
    .m_data       (m_data),
    .m_bytes      (m_bytes),
    .m_valid      (m_valid),
    .m_ready      (m_ready)
`ifdef FIFO_RD_CTRL_PARITY_EN
    ,
    .m_parity     (m_parity)
`endif
  );

  // FIFO model: registered read, empty reflects pops after the edge.
  logic [7:0] fifo_mem [0:63];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       force_empty;

  assign fifo_empty = (rd_ptr == wr_ptr) || force_empty;

  always @(posedge rd_clk) begin
    if (fifo_rd_en) begin
      fifo_rd_data <= fifo_mem[rd_ptr[5:0]];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  // Scoreboard and bookkeeping, all owned by the main process.
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          pop_cnt, first_pop, last_pop, rise_cyc;
  logic        prev_hold  = 1'b0;
  logic        prev_valid = 1'b0;
  logic [31:0] prev_data;
  logic [2:0]  prev_bytes;
  logic [31:0] exp_data  [0:31];
  logic [2:0]  exp_bytes [0:31];
  int          exp_wr = 0;
  int          exp_rd = 0;
  logic [7:0]  model_bytes [$];
  logic [31:0] last_word;
  logic [2:0]  last_bytes;
  logic        last_par;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Group queued bytes into words of PACK, first byte lowest; a flush
  // closes any remainder as a zero-padded partial word.
  task automatic model_close(input bit do_flush);
    logic [31:0] w;
    int          n;
    while (model_bytes.size() >= PACK) begin
      w = '0;
      for (int i = 0; i < PACK; i++) w[i*8 +: 8] = model_bytes.pop_front();
      exp_data[exp_wr]  = w;
      exp_bytes[exp_wr] = 3'(PACK);
      exp_wr++;
    end
    if (do_flush && (model_bytes.size() > 0)) begin
      n = model_bytes.size();
      w = '0;
      for (int i = 0; i < n; i++) w[i*8 +: 8] = model_bytes.pop_front();
      exp_data[exp_wr]  = w;
      exp_bytes[exp_wr] = 3'(n);
      exp_wr++;
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_ptr[5:0]] = b;
    wr_ptr++;
    model_bytes.push_back(b);
  endtask

  task automatic compare();
    if (fifo_empty) chk("no_pop_when_empty", 32'(fifo_rd_en), 32'd0);
    if (fifo_rd_en) begin
      if (pop_cnt == 0) first_pop = cyc;
      last_pop = cyc;
      pop_cnt++;
    end
    if (m_valid && !prev_valid && (rise_cyc < 0)) rise_cyc = cyc;
    if (prev_hold) begin
      chk("hold_valid", 32'(m_valid), 32'd1);
      chk("hold_data", m_data, prev_data);
      chk("hold_bytes", 32'(m_bytes), 32'(prev_bytes));
    end
    if (m_valid && m_ready) begin
      if (exp_rd >= exp_wr) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %h, expected none", m_data);
      end else begin
        chk("word_data", m_data, exp_data[exp_rd]);
        chk("word_bytes", 32'(m_bytes), 32'(exp_bytes[exp_rd]));
`ifdef FIFO_RD_CTRL_PARITY_EN
        chk("word_parity", 32'(m_parity), 32'(^exp_data[exp_rd]));
        last_par = m_parity;
`endif
        last_word  = m_data;
        last_bytes = m_bytes;
        exp_rd++;
      end
    end
    prev_hold  = m_valid && !m_ready && rd_rst_n;
    prev_valid = m_valid;
    prev_data  = m_data;
    prev_bytes = m_bytes;
  endtask

  // Inputs change at the falling edge; outputs are compared 1 time unit
  // later with the inputs that the next rising edge will sample.
  task automatic tick();
    #1;
    compare();
    cyc++;
    @(negedge rd_clk);
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp_rd < exp_wr) && (n < budget)) begin
      tick();
      n++;
    end
    if (exp_rd < exp_wr) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d words outstanding, expected 0", name, exp_wr - exp_rd);
    end
    repeat (3) tick();
  endtask

  task automatic wait_pops(input string name, input int target);
    int n = 0;
    while ((pop_cnt < target) && (n < 20)) begin
      tick();
      n++;
    end
    chk({name, "_pops_reached"}, 32'(pop_cnt), 32'(target));
  endtask

  task automatic begin_test();
    pop_cnt   = 0;
    first_pop = -1;
    last_pop  = -1;
    rise_cyc  = -1;
  endtask

  initial begin
    rd_rst_n    = 1'b0;
    flush       = 1'b0;
    m_ready     = 1'b0;
    force_empty = 1'b0;
    begin_test();
    @(negedge rd_clk);
    repeat (3) tick();
    #1;
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", m_data, 32'd0);
    chk("rst_bytes", 32'(m_bytes), 32'd0);
`ifdef FIFO_RD_CTRL_PARITY_EN
    chk("rst_parity", 32'(m_parity), 32'd0);
`endif
    rd_rst_n = 1'b1;
    tick();

    // Full word with continuous ready: latency and pop pattern.
    begin_test();
    m_ready = 1'b1;
    push(8'h34); push(8'h28); push(8'hAB); push(8'hCD);
    model_close(1'b0);
    drain("t1", 40);
    chk("t1_word", last_word, 32'hCDAB2834);
    chk("t1_bytes", 32'(last_bytes), 32'd4);
    chk("t1_pops", 32'(pop_cnt), 32'd4);
    chk("t1_pop_span", 32'(last_pop - first_pop), 32'd3);
    chk("t1_valid_latency", 32'(rise_cyc - first_pop), 32'd5);
`ifdef FIFO_RD_CTRL_PARITY_EN
    chk("t1_parity", 32'(last_par), 32'd1);
`endif

    // Three bytes then flush.
    begin_test();
    push(8'h34); push(8'h28); push(8'hAB);
    model_close(1'b0);
    repeat (8) tick();
    chk("t2_no_early_word", 32'(m_valid), 32'd0);
    flush = 1'b1;
    model_close(1'b1);
    tick();
    flush = 1'b0;
    drain("t2", 20);
    chk("t2_word", last_word, 32'h00AB2834);
    chk("t2_bytes", 32'(last_bytes), 32'd3);
    chk("t2_pops", 32'(pop_cnt), 32'd3);

    // Single-byte flush.
    begin_test();
    push(8'h03);
    repeat (5) tick();
    flush = 1'b1;
    model_close(1'b1);
    tick();
    flush = 1'b0;
    drain("t3", 20);
    chk("t3_word", last_word, 32'h00000003);
    chk("t3_bytes", 32'(last_bytes), 32'd1);
`ifdef FIFO_RD_CTRL_PARITY_EN
    chk("t3_parity", 32'(last_par), 32'd0);
`endif

    // Flush arriving while the only byte is still in flight.
    begin_test();
    push(8'h5A);
    wait_pops("t4", 1);
    flush = 1'b1;
    model_close(1'b1);
    tick();
    flush = 1'b0;
    drain("t4", 20);
    chk("t4_word", last_word, 32'h0000005A);
    chk("t4_bytes", 32'(last_bytes), 32'd1);

    // Flush with nothing buffered is ignored.
    repeat (3) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (4) tick();
    chk("t5_idle_valid", 32'(m_valid), 32'd0);

    // Backpressure: one word in the output slot, one held in the packer.
    begin_test();
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(8'(i));
    model_close(1'b0);
    repeat (20) tick();
    chk("t6_rd_en_blocked", 32'(fifo_rd_en), 32'd0);
    chk("t6_pops", 32'(pop_cnt), 32'd8);
    chk("t6_valid", 32'(m_valid), 32'd1);
    chk("t6_head_word", m_data, 32'h04030201);
    m_ready = 1'b1;
    drain("t6", 30);
    chk("t6_last_word", last_word, 32'h08070605);

    // Empty rises the cycle after the first pop.
    begin_test();
    push(8'h10); push(8'h20); push(8'h30); push(8'h40);
    model_close(1'b0);
    wait_pops("t7", 1);
    force_empty = 1'b1;
    repeat (10) tick();
    chk("t7_single_pop", 32'(pop_cnt), 32'd1);
    chk("t7_no_word", 32'(m_valid), 32'd0);
    force_empty = 1'b0;
    drain("t7", 30);
    chk("t7_word", last_word, 32'h40302010);
    chk("t7_pops", 32'(pop_cnt), 32'd4);

    // Reset with two bytes packed and one in flight.
    begin_test();
    push(8'hAA); push(8'hBB); push(8'hCC);
    wait_pops("t8", 3);
    rd_rst_n = 1'b0;
    tick();
    #1;
    chk("t8_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("t8_valid", 32'(m_valid), 32'd0);
    chk("t8_data", m_data, 32'd0);
    chk("t8_bytes", 32'(m_bytes), 32'd0);
    model_bytes.delete();
    rd_rst_n = 1'b1;
    tick();
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    model_close(1'b0);
    drain("t8", 30);
    chk("t8_word_slot0", last_word, 32'h44332211);
    chk("t8_scoreboard_empty", 32'(exp_wr - exp_rd), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-side drain controller for the dual-clock FIFO (`Fifo_Top_Module`). It lives entirely in the read clock domain and watches the FIFO empty flag. It issues `rd_en` pops while accounting for the FIFO's one-cycle registered read latency, and packs `PACK` consecutive bytes into one word. Each word is presented on a valid/ready stream to downstream logic, with a flush input for emitting partial words.

## Interface
- `DATA_W`, 8: width of one FIFO entry.
- `PACK`, 4: FIFO entries per output word; ≥2.

- `rd_clk` in 1: read-domain clock; all logic on rising edge.
- `rd_rst_n` in 1: synchronous, active-low reset.
- `fifo_empty` in 1: FIFO `o_fifo_empty`, already synchronous to `rd_clk`.
- `fifo_rd_en` out 1: pop request to FIFO `rd_en`.
- `fifo_rd_data` in DATA_W: FIFO `rd_data`; valid the cycle after `fifo_rd_en` was high.
- `flush` in 1: single-cycle request to emit the current partial word.
- `m_data` out DATA_W*PACK: packed word; byte 0 (first popped) in bits [DATA_W-1:0].
- `m_bytes` out $clog2(PACK)+1: valid bytes in `m_data`, 1..PACK.
- `m_valid` out 1: word available.
- `m_ready` in 1: downstream accepts; transfer when `m_valid && m_ready`.

## Operation
- Reset values: `fifo_rd_en`=0, `m_valid`=0, `m_data`=0, `m_bytes`=0. The internal byte count `cnt`, the in-flight flag and the pending-flush flag are all cleared.
- `fifo_rd_en` = `!fifo_empty && (cnt + inflight < PACK) && rst_n`. It is a registered-free combinational output of registered state and `fifo_empty`.
- `inflight` is set on the edge that samples `fifo_rd_en`=1 and clears on the following edge. On that following edge, `fifo_rd_data` is written into byte slot `cnt` and `cnt` increments.
- Completion: when the captured byte makes `cnt` reach PACK and the output slot is free or draining (`!m_valid || m_ready`):
  - The full word (pack bytes plus the captured byte) is loaded into `m_data` on that same edge.
  - `m_bytes` is set to PACK and `cnt` returns to 0.
  - Otherwise the word is held in the pack register with `cnt`=PACK, which blocks further pops. It moves out on the first edge the slot frees.
- Flush, when `cnt`>0:
  - With no in-flight byte: the partial word moves out when the slot frees. Unused bytes are zero, `m_bytes`=`cnt`, and `cnt` returns to 0.
  - With a byte in flight: the flush is latched as pending and applied after that capture.
  - With `cnt`=0 and nothing in flight: the flush is ignored.
  - While a flush is pending or being applied, `fifo_rd_en` is held low.
- Simultaneous flush and completion act as completion; the flush is consumed.
- Reset mid-operation discards any in-flight byte and any partial word. The FIFO side is reset together with this block.

## Timing
- Read latency is 1 cycle: `fifo_rd_en` high in cycle c means data is captured at the end of c+1.
- With the FIFO never empty and `m_ready`=1: pops occur in c..c+3, `m_valid` rises in c+5, and the next pop is in c+5. Sustained throughput is PACK bytes per PACK+1 cycles.
- `m_data`/`m_bytes` are stable while `m_valid && !m_ready`.
- When `fifo_empty` rises, at most the one already-issued byte is captured. No pop is issued while `fifo_empty`=1.

## Configuration
- `FIFO_RD_CTRL_PARITY_EN`:
  - Defined: adds output `m_parity` (1 bit), the even parity (XOR reduction) of the zero-padded `m_data`. It is registered with `m_data` and resets to 0.
  - Undefined: the port and its logic are absent.

## Structure
- Shared package `fifo_pkg`:
  - Default `DATA_W` and `PACK` localparams.
  - The `m_bytes` width function $clog2(PACK)+1.
  - The word-width constant DATA_W*PACK.
- One sub-module, `fifo_rd_pack`: byte-slot register array, `cnt` and zero-padding. The top level holds pop issue, `inflight`, flush-pending and the output register.

## Test plan
- FIFO preloaded with 34,28,AB,CD; `m_ready`=1 → one word `m_data`=CDAB2834, `m_bytes`=4. Pops on 4 consecutive cycles; `m_valid` rises 5 cycles after the first pop.
- FIFO holds 34,28,AB; `flush` after the third capture → `m_data`=00AB2834, `m_bytes`=3. No further pops.
- 8 bytes queued; `m_ready`=0 for 20 cycles → the first word is held stable and the second word is held in the pack register. `fifo_rd_en` stays low with 0 bytes lost; both words delivered in order after `m_ready`=1.
- `fifo_empty` rises the cycle after a pop → exactly one byte captured and `cnt`=1. `fifo_rd_en` stays 0 until `fifo_empty` falls.
- `rd_rst_n`=0 with 2 bytes packed and 1 in flight → next cycle all outputs are 0 and `cnt`=0. Subsequent bytes start at slot 0.
- With `FIFO_RD_CTRL_PARITY_EN` defined: word CDAB2834 → `m_parity`=1. Word 00000003 → `m_parity`=0.
